// File: rtl/if_id_elastic_pkg.sv
// Shared constants and the occupancy encoding for the IF->ID elastic stage.
package if_id_elastic_pkg;

  localparam logic        RstEnableN  = 1'b0;
  localparam int          InstAddrW   = 32;
  localparam int          InstW       = 32;
  localparam int          StallCntW   = 16;
  localparam logic [31:0] PipeNop     = 32'h0000_0000;

  // Occupancy is just {M.valid, S.valid}; S without M cannot legally occur.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BAD   = 2'b01,
    ST_HALF  = 2'b10,
    ST_FULL  = 2'b11
  } occ_e;

  function automatic occ_e occ_of(input logic m_vld, input logic s_vld);
    return occ_e'({m_vld, s_vld});
  endfunction

endpackage

// File: rtl/if_id_elastic_pipe_skid_slot.sv
// One pipeline slot: valid bit plus data, with synchronous clear taking priority over load.
// Cleared data is zero so an empty slot never exposes stale contents.
module if_id_elastic_pipe_skid_slot
  import if_id_elastic_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic              vld,
  output logic [DATA_W-1:0] dat
);

  logic              vld_d, vld_q;
  logic [DATA_W-1:0] dat_d, dat_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (clr) begin
      vld_d = 1'b0;
      dat_d = '0;
    end else if (ld) begin
      vld_d = 1'b1;
      dat_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnableN) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld = vld_q;
  assign dat = dat_q;

endmodule

// File: rtl/if_id_elastic.sv
// IF->ID stage register with valid/ready handshake, 2-entry skid (M drives ID, S absorbs
// back-pressure) and synchronous flush; if_ready comes straight from the S valid flop.
module if_id_elastic
  import if_id_elastic_pkg::*;
#(
  parameter int PC_W   = InstAddrW,
  parameter int INST_W = InstW,
  parameter int CNT_W  = StallCntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [PC_W-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int DATA_W = PC_W + INST_W;

  logic              m_vld, s_vld;
  logic [DATA_W-1:0] m_dat, s_dat;
  logic [DATA_W-1:0] in_dat, m_d;
  logic              m_ld, m_clr, s_ld, s_clr;
  logic              acc, take;
  occ_e              occ;
  logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;

  assign in_dat   = {if_pc, if_inst};
  assign if_ready = ~s_vld;
  assign acc      = if_valid & if_ready;
  assign take     = m_vld & id_ready;
  assign occ      = occ_of(m_vld, s_vld);

  always_comb begin
    m_ld  = 1'b0;
    m_clr = 1'b0;
    s_ld  = 1'b0;
    s_clr = 1'b0;
    m_d   = in_dat;
    if (flush) begin
      // A same-cycle take is still consumed by ID; only the held/incoming entries die.
      m_clr = 1'b1;
      s_clr = 1'b1;
    end else begin
      case (occ)
        ST_EMPTY: m_ld = acc;
        ST_HALF: begin
          if (acc && take)       m_ld  = 1'b1;
          else if (acc)          s_ld  = 1'b1;
          else if (take)         m_clr = 1'b1;
        end
        ST_FULL: begin
          if (take) begin
            m_ld  = 1'b1;
            m_d   = s_dat;
            s_clr = 1'b1;
          end
        end
        default: s_clr = 1'b1;
      endcase
    end
  end

  if_id_elastic_pipe_skid_slot #(.DATA_W(DATA_W)) u_slot_m (
    .clk (clk),
    .rst (rst),
    .ld  (m_ld),
    .clr (m_clr),
    .d   (m_d),
    .vld (m_vld),
    .dat (m_dat)
  );

  if_id_elastic_pipe_skid_slot #(.DATA_W(DATA_W)) u_slot_s (
    .clk (clk),
    .rst (rst),
    .ld  (s_ld),
    .clr (s_clr),
    .d   (in_dat),
    .vld (s_vld),
    .dat (s_dat)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_vld && !id_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnableN) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign id_valid  = m_vld;
  assign id_pc     = m_vld ? m_dat[DATA_W-1:INST_W] : '0;
  assign id_inst   = m_vld ? m_dat[INST_W-1:0]      : INST_W'(PipeNop);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_if_id_elastic.sv
// Scoreboard bench for if_id_elastic: directed stimulus pushes accepted entries, a negedge monitor checks outputs.
module tb_if_id_elastic;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [3:0]  stall_cnt;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q[$];
  logic [3:0]  stall_m = 4'h0;

  if_id_elastic #(.PC_W(32), .INST_W(32), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_pc     (id_pc),
    .id_inst   (id_inst),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, applied just after a rising edge and held through the next one.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    if_valid = v;
    if_pc    = v ? pc : 32'h0;
    if_inst  = v ? (32'h1300_0000 | pc) : 32'h0;
    id_ready = rdy;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  // Monitor: values sampled at negedge are exactly what the next rising edge acts on.
  initial begin
    logic exp_v, exp_r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        stall_m = 4'h0;
      end else begin
        exp_v = (exp_q.size() > 0);
        exp_r = (exp_q.size() < 2);
        chk("if_ready", {63'h0, if_ready}, {63'h0, exp_r});
        chk("id_valid", {63'h0, id_valid}, {63'h0, exp_v});
        chk("stall_cnt", {60'h0, stall_cnt}, {60'h0, stall_m});
        if (exp_v) chk("id_data", {id_pc, id_inst}, exp_q[0]);
        else       chk("id_nop", {id_pc, id_inst}, 64'h0);
        if (exp_v && !id_ready && stall_m != 4'hF) stall_m = stall_m + 4'h1;
        if (exp_v && id_ready) void'(exp_q.pop_front());
        if (flush) exp_q.delete();
        else if (if_valid && exp_r) exp_q.push_back({if_pc, if_inst});
      end
    end
  end

  initial begin
    rst = 1'b0; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; id_ready = 1'b0;
    #3;
    chk("rst0_id_valid", {63'h0, id_valid}, 64'h0);
    chk("rst0_if_ready", {63'h0, if_ready}, 64'h1);
    chk("rst0_id_inst", {32'h0, id_inst}, 64'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;

    // Streaming with ID always ready
    cyc(1'b1, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 32'h4, 1'b1, 1'b0);
    cyc(1'b1, 32'h8, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Async reset mid-traffic: everything drops without a clock edge
    cyc(1'b1, 32'h40, 1'b0, 1'b0);
    cyc(1'b1, 32'h44, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("arst_id_valid", {63'h0, id_valid}, 64'h0);
    chk("arst_id_pc", {32'h0, id_pc}, 64'h0);
    chk("arst_id_inst", {32'h0, id_inst}, 64'h0);
    chk("arst_stall", {60'h0, stall_cnt}, 64'h0);
    chk("arst_if_ready", {63'h0, if_ready}, 64'h1);
    @(posedge clk); #1;
    rst = 1'b1;

    // Back-pressure into FULL, then drain in order
    cyc(1'b1, 32'h10, 1'b0, 1'b0);
    cyc(1'b1, 32'h14, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("bp_full_if_ready", {63'h0, if_ready}, 64'h0);
    chk("bp_hold_pc", {32'h0, id_pc}, 64'h10);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush in FULL while IF offers 0x18
    cyc(1'b1, 32'h100, 1'b0, 1'b0);
    cyc(1'b1, 32'h104, 1'b0, 1'b0);
    cyc(1'b1, 32'h18, 1'b0, 1'b1);
    chk("flush_id_valid", {63'h0, id_valid}, 64'h0);
    chk("flush_id_inst", {32'h0, id_inst}, 64'h0);
    chk("flush_if_ready", {63'h0, if_ready}, 64'h1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush together with a take in HALF; 0x204 is dropped, 0x208 follows 0x200
    cyc(1'b1, 32'h200, 1'b1, 1'b0);
    cyc(1'b1, 32'h204, 1'b1, 1'b1);
    cyc(1'b1, 32'h208, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Saturation of the 4-bit stall counter
    cyc(1'b1, 32'h300, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("stall_sat", {60'h0, stall_cnt}, 64'hF);
    cyc(1'b1, 32'h304, 1'b0, 1'b1);
    chk("stall_after_flush", {60'h0, stall_cnt}, 64'hF);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
